// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for branch resolution in the EX stage:
//   - funct3 encodings of the conditional branch instructions
//   - 2-bit saturating counter states used by the branch history table
//   - helper functions for the taken/legal decode and counter update
// ---------------------------------------------------------------------------
package riscv_pkg;

    // funct3 encodings of the B-type conditional branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Branch history counter states; bit [1] is the prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,   // strong not-taken
        WNT = 2'b01,   // weak not-taken
        WT  = 2'b10,   // weak taken
        ST  = 2'b11    // strong taken
    } bht_state_e;

    // Outcome of decoding one branch against the comparator flags
    typedef struct packed {
        logic legal;   // funct3 names a real conditional branch
        logic taken;   // branch condition holds (0 when not legal)
    } br_decision_t;

    // Decide taken/not-taken from funct3 and the comparator flags.
    // The signed/unsigned distinction lives in the comparator itself, so
    // BLT/BLTU and BGE/BGEU share the same flag usage here.
    function automatic br_decision_t decide_branch(
        input logic [2:0] funct3,
        input logic       eq,
        input logic       lt
    );
        br_decision_t d;
        d.legal = 1'b1;
        d.taken = 1'b0;
        case (funct3)
            F3_BEQ:  d.taken = eq;
            F3_BNE:  d.taken = ~eq;
            F3_BLT:  d.taken = lt;
            F3_BGE:  d.taken = ~lt;
            F3_BLTU: d.taken = lt;
            F3_BGEU: d.taken = ~lt;
            default: begin
                // 010/011 are not branches: never taken, never counted
                d.legal = 1'b0;
                d.taken = 1'b0;
            end
        endcase
        return d;
    endfunction

    // Saturating 2-bit counter step: towards ST when taken, towards SNT
    // otherwise.
    function automatic bht_state_e bht_next(
        input bht_state_e state,
        input logic       taken
    );
        bht_state_e n;
        n = state;
        case (state)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bht.sv
// ---------------------------------------------------------------------------
// bht
// Branch history table of 2**BHT_BITS two-bit saturating counters.
//
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   rd_idx      : lookup index (from the fetch PC)
//   rd_pred     : combinational prediction, counter[1] of rd_idx
//   upd_en      : apply one counter update at the next rising edge
//   upd_idx     : entry to update
//   upd_taken   : resolved direction; increments when 1, decrements when 0
//
// Reset places every entry in weak not-taken. The read port sees the
// registered array only, so a lookup of the entry being updated in the same
// cycle returns the old value (read-before-write).
// ---------------------------------------------------------------------------
module bht
    import riscv_pkg::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic                rd_pred,
    input  logic                upd_en,
    input  logic [BHT_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int ENTRIES = 1 << BHT_BITS;

    bht_state_e ctr_q [ENTRIES];
    bht_state_e rd_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= bht_next(ctr_q[upd_idx], upd_taken);
        end
    end

    assign rd_state = ctr_q[rd_idx];
    assign rd_pred  = rd_state[1];

endmodule

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// EX-stage conditional branch resolution with BHT training, one-cycle
// flush/redirect on misprediction and saturating performance counters.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   ex_valid       : EX instruction valid
//   ex_is_branch   : EX instruction is a conditional branch
//   ex_funct3      : branch funct3
//   ex_pc          : PC of the EX instruction
//   ex_target      : computed branch target (pc + imm)
//   ex_pred_taken  : prediction made at fetch for this instruction
//   br_eq, br_lt   : comparator flags, valid in the same cycle
//   cmpop          : comparator mode, 0 signed / 1 unsigned (= funct3[1])
//   if_pc          : fetch PC used for the BHT lookup
//   if_pred_taken  : combinational BHT prediction for if_pc
//   flush          : one-cycle squash/redirect pulse
//   redirect_pc    : fetch redirect target, qualified by flush
//   branch_cnt     : number of legal resolved branches (saturating)
//   mispred_cnt    : number of mispredicted branches (saturating)
//
// Handshake: flush acts as a valid strobe for redirect_pc with no ready
// back-pressure; the consumer must take the redirect in the single cycle
// flush is high. redirect_pc holds its last value otherwise and carries no
// meaning while flush is low.
// ---------------------------------------------------------------------------
module branch_resolver
    import riscv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_BITS  = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [2:0]           ex_funct3,
    input  logic [WIDTH-1:0]     ex_pc,
    input  logic [WIDTH-1:0]     ex_target,
    input  logic                 ex_pred_taken,
    input  logic                 br_eq,
    input  logic                 br_lt,
    output logic                 cmpop,
    input  logic [WIDTH-1:0]     if_pc,
    output logic                 if_pred_taken,
    output logic                 flush,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    br_decision_t        dec;
    logic                resolve;
    logic                legal_resolve;
    logic                mispred;
    logic [WIDTH-1:0]    fallthrough_pc;
    logic [WIDTH-1:0]    correct_pc;
    logic [BHT_BITS-1:0] if_idx;
    logic [BHT_BITS-1:0] ex_idx;
    logic                unused_if_pc_bits;

    // Comparator mode follows funct3[1]: BLTU/BGEU are the unsigned forms
    assign cmpop = ex_funct3[1];

    assign dec = decide_branch(ex_funct3, br_eq, br_lt);

    // While flush is high the EX slot holds a squashed instruction, so
    // nothing it presents may resolve, train or count.
    assign resolve       = ex_valid & ex_is_branch & ~flush;
    assign legal_resolve = resolve & dec.legal;
    assign mispred       = legal_resolve & (dec.taken != ex_pred_taken);

    // Fall-through address wraps modulo 2**WIDTH
    assign fallthrough_pc = ex_pc + WIDTH'(4);
    assign correct_pc     = dec.taken ? ex_target : fallthrough_pc;

    // Word-aligned PCs: bits [1:0] never select an entry
    assign if_idx = if_pc[BHT_BITS+1:2];
    assign ex_idx = ex_pc[BHT_BITS+1:2];

    assign unused_if_pc_bits = ^{if_pc[WIDTH-1:BHT_BITS+2], if_pc[1:0]};

    bht #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_idx),
        .rd_pred   (if_pred_taken),
        .upd_en    (legal_resolve),
        .upd_idx   (ex_idx),
        .upd_taken (dec.taken)
    );

    // flush is a pure one-cycle pulse: it can never re-arm itself because
    // resolve is masked while it is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispred;
            if (mispred) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (legal_resolve && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (mispred && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
// Directed vectors with hand-computed expectations. Each driven cycle pushes
// the values every output must show in that cycle; a monitor on the falling
// edge pops and compares.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

    localparam int WIDTH     = 32;
    localparam int BHT_BITS  = 6;
    localparam int CNT_WIDTH = 16;

    typedef struct packed {
        logic [7:0]           tag;
        logic                 cmpop;
        logic                 if_pred;
        logic                 flush;
        logic [WIDTH-1:0]     redirect_pc;
        logic [CNT_WIDTH-1:0] branch_cnt;
        logic [CNT_WIDTH-1:0] mispred_cnt;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 ex_valid;
    logic                 ex_is_branch;
    logic [2:0]           ex_funct3;
    logic [WIDTH-1:0]     ex_pc;
    logic [WIDTH-1:0]     ex_target;
    logic                 ex_pred_taken;
    logic                 br_eq;
    logic                 br_lt;
    logic                 cmpop;
    logic [WIDTH-1:0]     if_pc;
    logic                 if_pred_taken;
    logic                 flush;
    logic [WIDTH-1:0]     redirect_pc;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   step_no;

    branch_resolver #(
        .WIDTH     (WIDTH),
        .BHT_BITS  (BHT_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .br_eq         (br_eq),
        .br_lt         (br_lt),
        .cmpop         (cmpop),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of EX/IF inputs and records what every output must
    // read during that same cycle (registered outputs reflect earlier edges).
    task automatic step(
        input logic              v,
        input logic              br,
        input logic [2:0]        f3,
        input logic [WIDTH-1:0]  pc,
        input logic [WIDTH-1:0]  tgt,
        input logic              pred,
        input logic              eq,
        input logic              lt,
        input logic [WIDTH-1:0]  ipc,
        input logic              e_cmpop,
        input logic              e_ifpred,
        input logic              e_flush,
        input logic [WIDTH-1:0]  e_redir,
        input int                e_bcnt,
        input int                e_mcnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        ex_valid      = v;
        ex_is_branch  = br;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        br_eq         = eq;
        br_lt         = lt;
        if_pc         = ipc;
        e.tag         = 8'(step_no);
        e.cmpop       = e_cmpop;
        e.if_pred     = e_ifpred;
        e.flush       = e_flush;
        e.redirect_pc = e_redir;
        e.branch_cnt  = CNT_WIDTH'(e_bcnt);
        e.mispred_cnt = CNT_WIDTH'(e_mcnt);
        exp_q.push_back(e);
        step_no++;
    endtask

    task automatic idle(
        input logic [WIDTH-1:0] ipc,
        input logic             e_ifpred,
        input logic             e_flush,
        input logic [WIDTH-1:0] e_redir,
        input int               e_bcnt,
        input int               e_mcnt
    );
        step(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0, ipc,
             1'b0, e_ifpred, e_flush, e_redir, e_bcnt, e_mcnt);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("c%0d cmpop", e.tag), 32'(cmpop), 32'(e.cmpop));
                check($sformatf("c%0d if_pred_taken", e.tag), 32'(if_pred_taken), 32'(e.if_pred));
                check($sformatf("c%0d flush", e.tag), 32'(flush), 32'(e.flush));
                check($sformatf("c%0d redirect_pc", e.tag), redirect_pc, e.redirect_pc);
                check($sformatf("c%0d branch_cnt", e.tag), 32'(branch_cnt), 32'(e.branch_cnt));
                check($sformatf("c%0d mispred_cnt", e.tag), 32'(mispred_cnt), 32'(e.mispred_cnt));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        checks        = 0;
        errors        = 0;
        step_no       = 0;
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_funct3     = 3'b000;
        ex_pc         = '0;
        ex_target     = '0;
        ex_pred_taken = 1'b0;
        br_eq         = 1'b0;
        br_lt         = 1'b0;
        if_pc         = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // c0: reset state
        idle(32'h40, 1'b0, 1'b0, 32'h0, 0, 0);
        // c1: BLT taken, predicted NT -> mispredict to target 0x80
        step(1'b1, 1'b1, 3'b100, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 32'h40,
             1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
        // c2: flush cycle; BHT[0] trained to weak-taken
        idle(32'h100, 1'b1, 1'b1, 32'h80, 1, 1);
        // c3: BGEU taken, predicted taken -> no flush
        step(1'b1, 1'b1, 3'b111, 32'h200, 32'h300, 1'b1, 1'b0, 1'b0, 32'h40,
             1'b1, 1'b0, 1'b0, 32'h80, 1, 1);
        // c4: BEQ at 0x40 not taken, predicted taken -> redirect 0x44
        step(1'b1, 1'b1, 3'b000, 32'h40, 32'h1000, 1'b1, 1'b0, 1'b0, 32'h100,
             1'b0, 1'b1, 1'b0, 32'h80, 2, 1);
        // c5: flush cycle; mispredicting BNE at 0x80 must be ignored
        step(1'b1, 1'b1, 3'b001, 32'h80, 32'h500, 1'b0, 1'b0, 1'b0, 32'h40,
             1'b0, 1'b0, 1'b1, 32'h44, 3, 2);
        // c6: no second flush, BHT entry of 0x80 untouched
        idle(32'h80, 1'b0, 1'b0, 32'h44, 3, 2);
        // c7: illegal funct3 010 with both flags set
        step(1'b1, 1'b1, 3'b010, 32'h80, 32'h600, 1'b0, 1'b1, 1'b1, 32'h80,
             1'b1, 1'b0, 1'b0, 32'h44, 3, 2);
        // c8: nothing changed by the illegal op
        idle(32'h80, 1'b0, 1'b0, 32'h44, 3, 2);
        // c9: BGE not taken at 0xFFFFFFFC, predicted taken -> wrap to 0
        step(1'b1, 1'b1, 3'b101, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC,
             1'b0, 1'b0, 1'b0, 32'h44, 3, 2);
        // c10: flush cycle with wrapped redirect
        idle(32'h100, 1'b1, 1'b1, 32'h0, 4, 3);

        // Reset asserted inside the flush cycle clears everything at once
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset flush", 32'(flush), 32'h0);
        check("async_reset redirect_pc", redirect_pc, 32'h0);
        check("async_reset branch_cnt", 32'(branch_cnt), 32'h0);
        check("async_reset mispred_cnt", 32'(mispred_cnt), 32'h0);
        check("async_reset if_pred_taken", 32'(if_pred_taken), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // c11: no residual redirect after reset release
        idle(32'h40, 1'b0, 1'b0, 32'h0, 0, 0);
        // c12..c14: train 0x40 taken back-to-back; first lookup sees old value
        step(1'b1, 1'b1, 3'b110, 32'h40, 32'h200, 1'b1, 1'b0, 1'b1, 32'h40,
             1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
        step(1'b1, 1'b1, 3'b110, 32'h40, 32'h200, 1'b1, 1'b0, 1'b1, 32'h40,
             1'b1, 1'b1, 1'b0, 32'h0, 1, 0);
        step(1'b1, 1'b1, 3'b110, 32'h40, 32'h200, 1'b1, 1'b0, 1'b1, 32'h40,
             1'b1, 1'b1, 1'b0, 32'h0, 2, 0);
        // c15: entry saturated at strong-taken
        idle(32'h40, 1'b1, 1'b0, 32'h0, 3, 0);

        // Let the monitor drain the queue, bounded
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
